// File: rtl/data_sync_ctrl.sv
// data_sync_ctrl: four-phase req/ack receiver in the destination clock domain.
// req is synchronized through a NUM_STAGES flop chain; unsync_bus is captured
// only on a capture edge, when req_s guarantees the foreign side holds it stable.
module data_sync_ctrl #(
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 req,
  input  logic                 dst_ready,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 ack,
  output logic                 busy,
  output logic                 err,
  output logic [7:0]           xfer_cnt
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_RDY = 2'd1;
  localparam logic [1:0] ACK      = 2'd2;

  logic [NUM_STAGES-1:0] req_sync;
  logic                  req_s;
  logic [1:0]            state;
  logic [1:0]            state_next;
  logic                  capture;
  logic                  abort;

  assign req_s = req_sync[NUM_STAGES-1];
  assign busy  = (state != IDLE);

  // Request synchronizer: the only logic that samples req.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[NUM_STAGES-2:0], req};
    end
  end

  // Next-state decode plus capture/abort qualifiers.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (req_s) begin
          if (dst_ready) begin
            capture    = 1'b1;
            state_next = ACK;
          end else begin
            state_next = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (!req_s) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (dst_ready) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and registered strobes; ack is high exactly while in ACK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      enable_pulse <= 1'b0;
      err          <= 1'b0;
      ack          <= 1'b0;
    end else begin
      state        <= state_next;
      enable_pulse <= capture;
      err          <= abort;
      ack          <= (state_next == ACK);
    end
  end

  // Data capture and completed-transfer counter (wraps modulo 256).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_bus <= '0;
      xfer_cnt <= '0;
    end else if (capture) begin
      sync_bus <= unsync_bus;
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end

endmodule
